chunk_adder: RTL

Parametrised multi-cycle adder/subtractor. It is the sequential successor to the 16-bit ripple-carry adder. Operands are processed CHUNK bits per clock, least-significant slice first, with the carry held in a register between slices. This trades latency for a short critical path. Valid/ready handshakes on both input and output let it sit between pipeline stages in the datapath.

---
 rtl/chunk_adder_if.sv | 42 ++++
 rtl/chunk_adder.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/chunk_adder_if.sv
// chunk_adder_if: handshake and data bundle for chunk_adder.
//   master : operand source and result consumer (drives in_valid, a, b, sub,
//            c_in, out_ready and, with CHUNK_ADDER_ACC_EN, acc_sel)
//   slave  : the adder (drives in_ready, out_valid, sum, c_out, ovf, busy)
// Optional feature macro: CHUNK_ADDER_ACC_EN adds acc_sel.
interface chunk_adder_if #(
  parameter int unsigned WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             c_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             c_out;
  logic             ovf;
  logic             busy;
`ifdef CHUNK_ADDER_ACC_EN
  logic             acc_sel;

  modport master (
    output in_valid, a, b, sub, c_in, out_ready, acc_sel,
    input  in_ready, out_valid, sum, c_out, ovf, busy
  );
  modport slave (
    input  in_valid, a, b, sub, c_in, out_ready, acc_sel,
    output in_ready, out_valid, sum, c_out, ovf, busy
  );
`else
  modport master (
    output in_valid, a, b, sub, c_in, out_ready,
    input  in_ready, out_valid, sum, c_out, ovf, busy
  );
  modport slave (
    input  in_valid, a, b, sub, c_in, out_ready,
    output in_ready, out_valid, sum, c_out, ovf, busy
  );
`endif
endinterface

// File: rtl/chunk_adder.sv
// chunk_adder: multi-cycle adder/subtractor, CHUNK bits per clock, LSB slice
// first, carry held in a register between slices.
// Ports:
//   clk  - clock, rising edge
//   rst  - synchronous active-high reset
//   bus  - chunk_adder_if.slave: in_valid/in_ready operand handshake with
//          a, b, sub, c_in; out_valid/out_ready result handshake with sum,
//          c_out, ovf; busy high while an operation is in flight.
// Optional feature macro: CHUNK_ADDER_ACC_EN (acc_sel selects an internal
// accumulator, loaded on each result handshake, as operand A).
module chunk_adder #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4
) (
  input  logic         clk,
  input  logic         rst,
  chunk_adder_if.slave bus
);

  localparam int unsigned     NCH     = WIDTH / CHUNK;
  localparam int unsigned     KW      = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [KW-1:0]   K_LAST  = KW'(NCH - 1);
  localparam logic [WIDTH-1:0] SL_MASK = {WIDTH{1'b1}} >> (WIDTH - CHUNK);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       r_state,     w_state_nxt;
  logic [WIDTH-1:0] r_a,         w_a_nxt;
  logic [WIDTH-1:0] r_b,         w_b_nxt;
  logic             r_carry,     w_carry_nxt;
  logic [KW-1:0]    r_k,         w_k_nxt;
  logic [WIDTH-1:0] r_sum,       w_sum_nxt;
  logic             r_c_out,     w_c_out_nxt;
  logic             r_ovf,       w_ovf_nxt;
  logic             r_out_valid, w_out_valid_nxt;
  logic             r_in_ready,  w_in_ready_nxt;
  logic             r_busy,      w_busy_nxt;

  logic [WIDTH-1:0] w_a_src;
  int unsigned      w_base;
  logic [CHUNK-1:0] w_a_sl;
  logic [CHUNK-1:0] w_b_sl;
  logic [CHUNK:0]   w_slice;
  logic [WIDTH-1:0] w_sum_slot;

`ifdef CHUNK_ADDER_ACC_EN
  logic [WIDTH-1:0] r_acc_q, w_acc_nxt;
  assign w_a_src = bus.acc_sel ? r_acc_q : bus.a;
`else
  assign w_a_src = bus.a;
`endif

  // Current slice: {carry, sum slice} = a slice + b' slice + carry
  assign w_base     = 32'(r_k) * CHUNK;
  assign w_a_sl     = CHUNK'(r_a >> w_base);
  assign w_b_sl     = CHUNK'(r_b >> w_base);
  assign w_slice    = {1'b0, w_a_sl} + {1'b0, w_b_sl} + (CHUNK+1)'(r_carry);
  assign w_sum_slot = (r_sum & ~(SL_MASK << w_base))
                    | (WIDTH'(w_slice[CHUNK-1:0]) << w_base);

  // Next-state and register-input logic
  always_comb begin
    w_state_nxt     = r_state;
    w_a_nxt         = r_a;
    w_b_nxt         = r_b;
    w_carry_nxt     = r_carry;
    w_k_nxt         = r_k;
    w_sum_nxt       = r_sum;
    w_c_out_nxt     = r_c_out;
    w_ovf_nxt       = r_ovf;
    w_out_valid_nxt = r_out_valid;
    w_in_ready_nxt  = r_in_ready;
    w_busy_nxt      = r_busy;
`ifdef CHUNK_ADDER_ACC_EN
    w_acc_nxt       = r_acc_q;
`endif
    case (r_state)
      S_IDLE: begin
        if (bus.in_valid) begin
          // Subtract is a + ~b + 1, so the carry seeds to 1 and c_in is ignored
          w_a_nxt        = w_a_src;
          w_b_nxt        = bus.sub ? ~bus.b : bus.b;
          w_carry_nxt    = bus.sub | bus.c_in;
          w_k_nxt        = '0;
          w_state_nxt    = S_RUN;
          w_in_ready_nxt = 1'b0;
          w_busy_nxt     = 1'b1;
        end
      end
      S_RUN: begin
        w_sum_nxt   = w_sum_slot;
        w_carry_nxt = w_slice[CHUNK];
        w_k_nxt     = r_k + KW'(1);
        if (r_k == K_LAST) begin
          w_k_nxt         = '0;
          w_state_nxt     = S_DONE;
          w_out_valid_nxt = 1'b1;
          w_c_out_nxt     = w_slice[CHUNK];
          w_ovf_nxt       = (r_a[WIDTH-1] == r_b[WIDTH-1])
                         && (w_sum_slot[WIDTH-1] != r_a[WIDTH-1]);
        end
      end
      S_DONE: begin
        if (bus.out_ready) begin
          w_state_nxt     = S_IDLE;
          w_out_valid_nxt = 1'b0;
          w_in_ready_nxt  = 1'b1;
          w_busy_nxt      = 1'b0;
`ifdef CHUNK_ADDER_ACC_EN
          w_acc_nxt       = r_sum;
`endif
        end
      end
      default: begin
        w_state_nxt     = S_IDLE;
        w_out_valid_nxt = 1'b0;
        w_in_ready_nxt  = 1'b1;
        w_busy_nxt      = 1'b0;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_carry     <= 1'b0;
      r_k         <= '0;
      r_sum       <= '0;
      r_c_out     <= 1'b0;
      r_ovf       <= 1'b0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
      r_busy      <= 1'b0;
`ifdef CHUNK_ADDER_ACC_EN
      r_acc_q     <= '0;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_a         <= w_a_nxt;
      r_b         <= w_b_nxt;
      r_carry     <= w_carry_nxt;
      r_k         <= w_k_nxt;
      r_sum       <= w_sum_nxt;
      r_c_out     <= w_c_out_nxt;
      r_ovf       <= w_ovf_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_in_ready  <= w_in_ready_nxt;
      r_busy      <= w_busy_nxt;
`ifdef CHUNK_ADDER_ACC_EN
      r_acc_q     <= w_acc_nxt;
`endif
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.sum       = r_sum;
  assign bus.c_out     = r_c_out;
  assign bus.ovf       = r_ovf;
  assign bus.busy      = r_busy;

endmodule
